// File: rtl/pool_window_buffer_pkg.sv
// Shared constants for the pooling window buffer and the pooling stage it feeds.
// Counter widths are derived here so both sides agree on them.
package pool_window_buffer_pkg;
   localparam int DEF_STRIDE_SIZE = 2;
   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_ROW_SIZE    = 28;
   localparam int DEF_COLUMN_SIZE = 28;
   localparam int NUM_INP         = DEF_STRIDE_SIZE * DEF_STRIDE_SIZE;
   localparam int COL_CNT_W       = $clog2(DEF_ROW_SIZE);
   localparam int ROW_CNT_W       = $clog2(DEF_COLUMN_SIZE);

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/pool_line_store.sv
// Holds the STRIDE_SIZE-1 most recent full image rows of the current window band.
// Column-indexed write, and a STRIDE_SIZE-wide read starting at the window's left column.
module pool_line_store
   import pool_window_buffer_pkg::*;
#(
   parameter int STRIDE_SIZE = DEF_STRIDE_SIZE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ROW_SIZE    = DEF_ROW_SIZE,
   parameter int COL_W       = cnt_w(DEF_ROW_SIZE),
   parameter int PH_W        = cnt_w(DEF_STRIDE_SIZE)
) (
   input  logic                                              clock,
   input  logic                                              wr_en_i,
   input  logic [PH_W-1:0]                                   wr_row_i,
   input  logic [COL_W-1:0]                                  wr_col_i,
   input  logic [DATA_WIDTH-1:0]                             wr_data_i,
   input  logic [COL_W-1:0]                                  rd_col_i,
   output logic [(STRIDE_SIZE-1)*STRIDE_SIZE*DATA_WIDTH-1:0] rd_data_o
);
   logic [DATA_WIDTH-1:0] mem_q [STRIDE_SIZE-1][ROW_SIZE];

   // Storage is never cleared: every word is rewritten before any window reads it.
   always_ff @(posedge clock) begin
      for (int r = 0; r < STRIDE_SIZE-1; r++) begin
         for (int c = 0; c < ROW_SIZE; c++) begin
            if (wr_en_i && wr_row_i == PH_W'(r) && wr_col_i == COL_W'(c)) begin
               mem_q[r][c] <= wr_data_i;
            end
         end
      end
   end

   always_comb begin
      rd_data_o = '0;
      for (int r = 0; r < STRIDE_SIZE-1; r++) begin
         for (int wc = 0; wc < STRIDE_SIZE; wc++) begin
            for (int c = 0; c < ROW_SIZE; c++) begin
               if (rd_col_i + COL_W'(wc) == COL_W'(c)) begin
                  rd_data_o[(r*STRIDE_SIZE+wc)*DATA_WIDTH +: DATA_WIDTH] = mem_q[r][c];
               end
            end
         end
      end
   end
endmodule

// File: rtl/pool_window_buffer.sv
// Turns a raster pixel stream into non-overlapping STRIDE_SIZE x STRIDE_SIZE windows.
// A pixel is taken on any posedge where pixel_in_valid is high; there is no backpressure.
module pool_window_buffer
   import pool_window_buffer_pkg::*;
#(
   parameter int STRIDE_SIZE = DEF_STRIDE_SIZE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ROW_SIZE    = DEF_ROW_SIZE,
   parameter int COLUMN_SIZE = DEF_COLUMN_SIZE
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic [DATA_WIDTH-1:0]                       pixel_in,
   input  logic                                        pixel_in_valid,
   output logic [STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH-1:0] window_out,
   output logic                                        window_valid,
   output logic                                        frame_done
);
   localparam int COL_W = cnt_w(ROW_SIZE);
   localparam int ROW_W = cnt_w(COLUMN_SIZE);
   localparam int PH_W  = cnt_w(STRIDE_SIZE);
   localparam int WIN_W = STRIDE_SIZE * STRIDE_SIZE * DATA_WIDTH;
   localparam int LS_W  = (STRIDE_SIZE-1) * STRIDE_SIZE * DATA_WIDTH;

   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [PH_W-1:0]       col_ph_q, col_ph_d, row_ph_q, row_ph_d;
   logic [DATA_WIDTH-1:0] cur_q [STRIDE_SIZE-1];
   logic [LS_W-1:0]       ls_rd;
   logic [WIN_W-1:0]      win_d, window_q;
   logic                  valid_q, done_q;
   logic                  last_col, last_row, complete, ls_we;

   assign last_col = (col_q == COL_W'(ROW_SIZE-1));
   assign last_row = (row_q == ROW_W'(COLUMN_SIZE-1));
   // Trailing columns/rows that cannot fill a window never reach phase STRIDE_SIZE-1.
   assign complete = pixel_in_valid && (col_ph_q == PH_W'(STRIDE_SIZE-1))
                     && (row_ph_q == PH_W'(STRIDE_SIZE-1));
   assign ls_we    = pixel_in_valid && (row_ph_q != PH_W'(STRIDE_SIZE-1));

   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      col_ph_d = col_ph_q;
      row_ph_d = row_ph_q;
      if (pixel_in_valid) begin
         if (last_col) begin
            col_d    = '0;
            col_ph_d = '0;
            if (last_row) begin
               row_d    = '0;
               row_ph_d = '0;
            end else begin
               row_d    = row_q + ROW_W'(1);
               row_ph_d = (row_ph_q == PH_W'(STRIDE_SIZE-1)) ? '0 : row_ph_q + PH_W'(1);
            end
         end else begin
            col_d    = col_q + COL_W'(1);
            col_ph_d = (col_ph_q == PH_W'(STRIDE_SIZE-1)) ? '0 : col_ph_q + PH_W'(1);
         end
      end
   end

   // Upper rows come from the line store; the bottom row is the shift register plus this pixel.
   always_comb begin
      win_d            = '0;
      win_d[LS_W-1:0]  = ls_rd;
      for (int wc = 0; wc < STRIDE_SIZE-1; wc++) begin
         win_d[((STRIDE_SIZE-1)*STRIDE_SIZE+wc)*DATA_WIDTH +: DATA_WIDTH] = cur_q[wc];
      end
      win_d[WIN_W-1 -: DATA_WIDTH] = pixel_in;
   end

   pool_line_store #(
      .STRIDE_SIZE(STRIDE_SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_SIZE   (ROW_SIZE),
      .COL_W      (COL_W),
      .PH_W       (PH_W)
   ) u_line_store (
      .clock    (clock),
      .wr_en_i  (ls_we),
      .wr_row_i (row_ph_q),
      .wr_col_i (col_q),
      .wr_data_i(pixel_in),
      .rd_col_i (col_q - COL_W'(STRIDE_SIZE-1)),
      .rd_data_o(ls_rd)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col_q    <= '0;
         row_q    <= '0;
         col_ph_q <= '0;
         row_ph_q <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         window_q <= '0;
         for (int i = 0; i < STRIDE_SIZE-1; i++) cur_q[i] <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         col_ph_q <= col_ph_d;
         row_ph_q <= row_ph_d;
         valid_q  <= complete;
         done_q   <= pixel_in_valid && last_col && last_row;
         if (complete) window_q <= win_d;
         if (pixel_in_valid) begin
            for (int i = 0; i < STRIDE_SIZE-2; i++) cur_q[i] <= cur_q[i+1];
            cur_q[STRIDE_SIZE-2] <= pixel_in;
         end
      end
   end

   assign window_out   = window_q;
   assign window_valid = valid_q;
   assign frame_done   = done_q;
endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer: a 4x4 and a 5x5 instance see the same stream and
// are compared every cycle against a frame-image model, plus hand-computed windows.
module tb_pool_window_buffer;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pixel_in = '0;
   logic        pixel_in_valid = 1'b0;
   logic [63:0] win4, win5;
   logic        wv4, wv5, fd4, fd5;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   pool_window_buffer #(.STRIDE_SIZE(2), .DATA_WIDTH(16), .ROW_SIZE(4), .COLUMN_SIZE(4)) dut4 (
      .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
      .window_out(win4), .window_valid(wv4), .frame_done(fd4));

   pool_window_buffer #(.STRIDE_SIZE(2), .DATA_WIDTH(16), .ROW_SIZE(5), .COLUMN_SIZE(5)) dut5 (
      .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
      .window_out(win5), .window_valid(wv5), .frame_done(fd5));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   // Model: remember the frame image, emit a window when its bottom-right pixel arrives.
   int          rs[2] = '{4, 5};
   int          cs[2] = '{4, 5};
   int          mr[2], mc[2];
   logic [15:0] img[2][5][5];
   logic [63:0] ew[2];
   logic        ev[2], ed[2];
   int          last_px;

   always @(posedge clock) begin
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            mr[m] = 0; mc[m] = 0; ev[m] = 1'b0; ed[m] = 1'b0; ew[m] = '0;
         end else begin
            ev[m] = 1'b0;
            ed[m] = 1'b0;
            if (pixel_in_valid) begin
               img[m][mr[m]][mc[m]] = pixel_in;
               if (mr[m] % 2 == 1 && mc[m] % 2 == 1 &&
                   mc[m] < (rs[m] / 2) * 2 && mr[m] < (cs[m] / 2) * 2) begin
                  ev[m] = 1'b1;
                  for (int wr = 0; wr < 2; wr++)
                     for (int wc = 0; wc < 2; wc++)
                        ew[m][(wr*2+wc)*16 +: 16] = img[m][mr[m]-1+wr][mc[m]-1+wc];
               end
               ed[m] = (mr[m] == cs[m]-1 && mc[m] == rs[m]-1);
               if (mc[m] == rs[m]-1) begin
                  mc[m] = 0;
                  mr[m] = (mr[m] == cs[m]-1) ? 0 : mr[m] + 1;
               end else begin
                  mc[m] = mc[m] + 1;
               end
            end
         end
      end
      if (!reset && pixel_in_valid) last_px = int'(pixel_in);
   end

   logic [63:0] got4[$], got5[$];
   int          gpx4[$], gpx5[$];
   int          n_done4, n_done5;
   logic [63:0] exp_q[$];

   always @(posedge clock) begin
      #1;
      check("valid4", wv4, ev[0]);
      check("done4", fd4, ed[0]);
      check("window4", win4, ew[0]);
      check("valid5", wv5, ev[1]);
      check("done5", fd5, ed[1]);
      check("window5", win5, ew[1]);
      if (wv4) begin got4.push_back(win4); gpx4.push_back(last_px); end
      if (wv5) begin got5.push_back(win5); gpx5.push_back(last_px); end
      if (fd4) n_done4++;
      if (fd5) n_done5++;
   end

   task automatic send(input int v, input bit valid);
      @(negedge clock);
      pixel_in       = 16'(v);
      pixel_in_valid = valid;
   endtask

   // gaps: 0 continuous, 1 one idle cycle per pixel, 2 random 0..3 idle cycles
   task automatic stream(input int base, input int n, input int gaps);
      for (int i = 0; i < n; i++) begin
         send(base + i, 1'b1);
         if (gaps == 1) send(int'($urandom_range(0, 65535)), 1'b0);
         if (gaps == 2) begin
            int g = int'($urandom_range(0, 3));
            for (int j = 0; j < g; j++) send(int'($urandom_range(0, 65535)), 1'b0);
         end
      end
      for (int i = 0; i < 3; i++) send(0, 1'b0);
   endtask

   task automatic clear_log();
      got4.delete(); got5.delete(); gpx4.delete(); gpx5.delete();
      n_done4 = 0; n_done5 = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      pixel_in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      clear_log();
   endtask

   task automatic check_got4(input string tag);
      check({tag, "_count"}, 64'(got4.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) check({tag, "_win"}, got4[i], exp_q[i]);
      exp_q.delete();
   endtask

   initial begin
      // Reset held with live input: everything must stay at zero.
      for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 65535)), 1'b1);
      @(negedge clock);
      check("rst_win4", win4, 64'd0);
      check("rst_valid5", {63'd0, wv5}, 64'd0);
      reset = 1'b0;
      pixel_in_valid = 1'b0;
      clear_log();

      // Continuous 4x4 frame
      stream(0, 16, 0);
      exp_q = '{pk(0, 1, 4, 5), pk(2, 3, 6, 7), pk(8, 9, 12, 13), pk(10, 11, 14, 15)};
      check_got4("cont");
      check("cont_px0", 64'(gpx4[0]), 64'd5);
      check("cont_px1", 64'(gpx4[1]), 64'd7);
      check("cont_px2", 64'(gpx4[2]), 64'd13);
      check("cont_px3", 64'(gpx4[3]), 64'd15);
      check("cont_done", 64'(n_done4), 64'd1);

      // Valid toggled every cycle
      do_reset();
      stream(0, 16, 1);
      exp_q = '{pk(0, 1, 4, 5), pk(2, 3, 6, 7), pk(8, 9, 12, 13), pk(10, 11, 14, 15)};
      check_got4("toggle");
      check("toggle_px3", 64'(gpx4[3]), 64'd15);

      // 5x5 frame: trailing column and row produce nothing
      do_reset();
      stream(0, 25, 0);
      check("odd_count", 64'(got5.size()), 64'd4);
      check("odd_first", got5[0], pk(0, 1, 5, 6));
      check("odd_last", got5[3], pk(12, 13, 17, 18));
      check("odd_px1", 64'(gpx5[1]), 64'd8);
      check("odd_done", 64'(n_done5), 64'd1);

      // Reset in mid-frame
      do_reset();
      for (int i = 0; i < 10; i++) send(i, 1'b1);
      do_reset();
      stream(100, 16, 0);
      exp_q = '{pk(100, 101, 104, 105), pk(102, 103, 106, 107),
                pk(108, 109, 112, 113), pk(110, 111, 114, 115)};
      check_got4("midrst");

      // Back-to-back frames
      do_reset();
      stream(0, 32, 0);
      check("b2b_count", 64'(got4.size()), 64'd8);
      check("b2b_first2", got4[4], pk(16, 17, 20, 21));
      check("b2b_done", 64'(n_done4), 64'd2);

      // Random gaps over three frames, model-checked only
      do_reset();
      stream(200, 48, 2);
      check("gaps_done", 64'(n_done4), 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pool_window_buffer.md
POOL_WINDOW_BUFFER -- requirements
Module: pool_window_buffer

Interface
REQ-001 Parameter STRIDE_SIZE, default 2, pooling window edge and stride; windows do not overlap.
REQ-002 Parameter DATA_WIDTH, default 16, width of one pixel word; treated as opaque bits.
REQ-003 Parameter ROW_SIZE, default 28, pixels per image row.
REQ-004 Parameter COLUMN_SIZE, default 28, rows per frame.
REQ-005 clock  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 pixel_in  input  DATA_WIDTH  raster-order pixel, row-major, top-left first.
REQ-008 pixel_in_valid  input  1  pixel_in accepted on the current posedge when high.
REQ-009 window_out  output  STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH  packed window feeding the pooling stage.
REQ-010 window_valid  output  1  one-cycle strobe: window_out holds a complete window.
REQ-011 frame_done  output  1  one-cycle strobe: last pixel of frame accepted.

Function
REQ-012 Block SHALL keep col_cnt (0..ROW_SIZE-1) and row_cnt (0..COLUMN_SIZE-1), advanced only on accepted pixels.
REQ-013 col_cnt SHALL wrap to 0 after ROW_SIZE-1 and increment row_cnt; row_cnt SHALL wrap to 0 after COLUMN_SIZE-1.
REQ-014 Pixel at (row r, col c) SHALL be stored in line-store row r mod STRIDE_SIZE, column c; STRIDE_SIZE-1 full rows plus the current row are retained.
REQ-015 Window SHALL complete when accepted pixel has c mod STRIDE_SIZE = STRIDE_SIZE-1 and r mod STRIDE_SIZE = STRIDE_SIZE-1.
REQ-016 Windows whose columns exceed (ROW_SIZE/STRIDE_SIZE)*STRIDE_SIZE-1 or rows exceed (COLUMN_SIZE/STRIDE_SIZE)*STRIDE_SIZE-1 SHALL be discarded (no partial windows).
REQ-017 Packing: element at window-local (wr, wc), wr=0 top, wc=0 left, SHALL occupy slice index k = wr*STRIDE_SIZE+wc, bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-018 Latency: window_out and window_valid SHALL be registered, asserted the cycle after the completing pixel is accepted.
REQ-019 window_out SHALL hold its last value until the next window completes; window_valid SHALL be high exactly one cycle per window.
REQ-020 frame_done SHALL assert the cycle after pixel (COLUMN_SIZE-1, ROW_SIZE-1) is accepted, coincident with that frame's last window_valid if one exists.
REQ-021 pixel_in_valid low SHALL freeze counters and storage; arbitrary gaps SHALL not alter window contents.
REQ-022 No backpressure: downstream SHALL capture window_out on window_valid; consecutive windows SHALL be spaced at least STRIDE_SIZE accepted pixels apart.
REQ-023 Next frame SHALL start immediately after frame_done with no idle cycle required; stale line-store data SHALL never appear in a window.

Reset
REQ-024 On reset: col_cnt=0, row_cnt=0, window_valid=0, frame_done=0, window_out=0; line-store contents need not be cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame; first pixel after release SHALL be treated as (0,0).

Structure
REQ-026 Shared header SHALL hold NUM_INP = STRIDE_SIZE*STRIDE_SIZE and counter widths $clog2(ROW_SIZE), $clog2(COLUMN_SIZE), shared with the pooling stage.
REQ-027 One sub-module pool_line_store SHALL implement the (STRIDE_SIZE-1)-row by ROW_SIZE register array with column-indexed write and STRIDE_SIZE-wide parallel read.
REQ-028 Counters, window-complete detect, current-row shift register and output registers SHALL reside in pool_window_buffer.

Verification (STRIDE_SIZE=2, DATA_WIDTH=16, ROW_SIZE=4, COLUMN_SIZE=4 unless noted)
REQ-029 Pixels 0..15 (value = index), valid continuous -> window_valid after pixels 5,7,13,15; first window slices k0..k3 = 0,1,4,5; last = 10,11,14,15; frame_done with last.
REQ-030 Same stream, valid toggled 1/0 every cycle -> identical four windows, each one cycle after its completing pixel.
REQ-031 ROW_SIZE=5, COLUMN_SIZE=5, pixels 0..24 -> exactly 4 windows (first 0,1,5,6; last 12,13,17,18); column 4 and row 4 discarded; frame_done after pixel 24.
REQ-032 Reset pulse after pixel 9, then pixels 100..115 -> first window 100,101,104,105; no window containing pre-reset data.
REQ-033 Two back-to-back frames (0..15 then 16..31) -> second frame first window 16,17,20,21; two frame_done pulses.
REQ-034 Reset held high with valid input -> all outputs 0, counters 0.
